// File: rtl/line_fill_buffer_pkg.sv
// Shared types and constants for the I-cache line fill buffer.
package line_fill_buffer_pkg;

    localparam int unsigned LFB_ADDR_W = 32;
    localparam int unsigned LFB_DATA_W = 32;
    localparam int unsigned LFB_WORDS  = 4;
    localparam int unsigned LFB_IDX_W  = 2;

    // Byte offset within a 16-byte line.
    localparam logic [31:0] LINE_OFFSET_MASK = 32'h0000_000F;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_FILL,
        FILL_WRITE
    } fill_state_e;

    // Line base of an address: clears the in-line byte offset.
    function automatic logic [LFB_ADDR_W-1:0] line_base(input logic [LFB_ADDR_W-1:0] addr);
        return addr & ~LFB_ADDR_W'(LINE_OFFSET_MASK);
    endfunction

endpackage

// File: rtl/line_fill_buffer.sv
// Collects the four beats of a WRAP4 refill into one aligned line, forwards the
// critical word as soon as it arrives, and holds the line for the cache write port.
module line_fill_buffer
    import line_fill_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = LFB_ADDR_W,
    parameter int unsigned DATA_W = LFB_DATA_W,
    parameter int unsigned WORDS  = LFB_WORDS
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      fill_start,
    input  logic [ADDR_W-1:0]         fill_addr,
    input  logic                      beat_valid,
    input  logic [ADDR_W-1:0]         beat_addr,
    input  logic [DATA_W-1:0]         beat_data,
    input  logic                      beat_err,
    output logic                      busy,
    output logic                      crit_valid,
    output logic [DATA_W-1:0]         crit_data,
    output logic                      line_valid,
    output logic [ADDR_W-1:0]         line_addr,
    output logic [WORDS*DATA_W-1:0]   line_data,
    input  logic                      line_accept,
    output logic                      fill_error
);

    fill_state_e                         state_q, state_d;
    logic [ADDR_W-1:0]                   base_q, base_d;
    logic [LFB_IDX_W-1:0]                crit_idx_q, crit_idx_d;
    logic [WORDS-1:0]                    mask_q, mask_d;
    logic [WORDS-1:0][DATA_W-1:0]        words_q, words_d;
    logic                                crit_valid_q, crit_valid_d;
    logic [DATA_W-1:0]                   crit_data_q, crit_data_d;
    logic                                line_valid_q, line_valid_d;
    logic                                fill_error_q, fill_error_d;
    logic                                busy_q, busy_d;

    logic [LFB_IDX_W-1:0]                beat_idx;
    logic                                beat_hit;
    logic [WORDS-1:0]                    mask_set;
    logic                                unused_addr_bits;

    assign beat_idx         = beat_addr[3:2];
    assign beat_hit         = beat_valid && (beat_addr[ADDR_W-1:4] == base_q[ADDR_W-1:4]);
    assign mask_set         = mask_q | (WORDS'(1) << beat_idx);
    assign unused_addr_bits = ^beat_addr[1:0];

    // Next-state, beat capture and output pulse generation.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        crit_idx_d   = crit_idx_q;
        mask_d       = mask_q;
        words_d      = words_q;
        crit_data_d  = crit_data_q;
        crit_valid_d = 1'b0;
        fill_error_d = 1'b0;

        case (state_q)
            FILL_IDLE: begin
                if (fill_start) begin
                    state_d    = FILL_FILL;
                    base_d     = line_base(fill_addr);
                    crit_idx_d = fill_addr[3:2];
                    mask_d     = '0;
                end
            end
            FILL_FILL: begin
                if (beat_valid && beat_err) begin
                    // Abort: erroring beat's data is dropped, partial line forgotten.
                    state_d      = FILL_IDLE;
                    mask_d       = '0;
                    fill_error_d = 1'b1;
                end else if (beat_hit) begin
                    words_d[beat_idx] = beat_data;
                    mask_d            = mask_set;
                    if ((beat_idx == crit_idx_q) && !mask_q[crit_idx_q]) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = beat_data;
                    end
                    if (mask_set == '1) begin
                        state_d = FILL_WRITE;
                    end
                end
            end
            FILL_WRITE: begin
                if (line_accept) begin
                    if (fill_start) begin
                        state_d    = FILL_FILL;
                        base_d     = line_base(fill_addr);
                        crit_idx_d = fill_addr[3:2];
                        mask_d     = '0;
                    end else begin
                        state_d = FILL_IDLE;
                    end
                end
            end
            default: begin
                state_d = FILL_IDLE;
                mask_d  = '0;
            end
        endcase

        busy_d       = (state_d != FILL_IDLE);
        line_valid_d = (state_d == FILL_WRITE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FILL_IDLE;
            base_q       <= '0;
            crit_idx_q   <= '0;
            mask_q       <= '0;
            words_q      <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            line_valid_q <= 1'b0;
            fill_error_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            crit_idx_q   <= crit_idx_d;
            mask_q       <= mask_d;
            words_q      <= words_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            line_valid_q <= line_valid_d;
            fill_error_q <= fill_error_d;
            busy_q       <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
    assign line_valid = line_valid_q;
    assign line_addr  = base_q;
    assign line_data  = words_q;
    assign fill_error = fill_error_q;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Bench for line_fill_buffer: vector tables, directed corner sequences and a
// randomized transaction-level refill model.
module tb_line_fill_buffer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         fill_start;
    logic [31:0]  fill_addr;
    logic         beat_valid;
    logic [31:0]  beat_addr;
    logic [31:0]  beat_data;
    logic         beat_err;
    logic         busy;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         line_valid;
    logic [31:0]  line_addr;
    logic [127:0] line_data;
    logic         line_accept;
    logic         fill_error;

    int checks = 0;
    int errors = 0;

    line_fill_buffer dut (
        .clk         (clk),
        .rstn        (rstn),
        .fill_start  (fill_start),
        .fill_addr   (fill_addr),
        .beat_valid  (beat_valid),
        .beat_addr   (beat_addr),
        .beat_data   (beat_data),
        .beat_err    (beat_err),
        .busy        (busy),
        .crit_valid  (crit_valid),
        .crit_data   (crit_data),
        .line_valid  (line_valid),
        .line_addr   (line_addr),
        .line_data   (line_data),
        .line_accept (line_accept),
        .fill_error  (fill_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           fs;
        logic [31:0]  fa;
        bit           bv;
        logic [31:0]  ba;
        logic [31:0]  bd;
        bit           be;
        bit           la;
        bit           e_busy;
        bit           e_cv;
        logic [31:0]  e_cd;
        bit           e_lv;
        bit           e_fe;
        bit           e_line;
        logic [31:0]  e_la;
        logic [127:0] e_ld;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        bit          e;
    } beat_t;

    localparam logic [31:0] A0 = 32'hA0A0_0000, A1 = 32'hA1A1_1111,
                            A2 = 32'hA2A2_2222, A3 = 32'hA3A3_3333;
    localparam logic [31:0] B0 = 32'hB0B0_0000, B1 = 32'hB1B1_1111,
                            B2 = 32'hB2B2_2222, B3 = 32'hB3B3_3333;
    localparam logic [31:0] C0 = 32'hC0C0_0000, C1 = 32'hC1C1_1111,
                            C2 = 32'hC2C2_2222, C3 = 32'hC3C3_3333;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input bit e_busy, input bit e_cv,
                               input logic [31:0] e_cd, input bit e_lv, input bit e_fe,
                               input bit e_line, input logic [31:0] e_la,
                               input logic [127:0] e_ld);
        chk($sformatf("%s busy", tag), 128'(busy), 128'(e_busy));
        chk($sformatf("%s crit_valid", tag), 128'(crit_valid), 128'(e_cv));
        if (e_cv) chk($sformatf("%s crit_data", tag), 128'(crit_data), 128'(e_cd));
        chk($sformatf("%s line_valid", tag), 128'(line_valid), 128'(e_lv));
        chk($sformatf("%s fill_error", tag), 128'(fill_error), 128'(e_fe));
        if (e_line) begin
            chk($sformatf("%s line_addr", tag), 128'(line_addr), 128'(e_la));
            chk($sformatf("%s line_data", tag), line_data, e_ld);
        end
    endtask

    task automatic exp_s(input string tag, input bit e_busy, input bit e_cv,
                         input logic [31:0] e_cd, input bit e_lv, input bit e_fe);
        expect_outs(tag, e_busy, e_cv, e_cd, e_lv, e_fe, 1'b0, '0, '0);
    endtask

    // Drive one cycle of inputs at the falling edge, return at the next falling edge.
    task automatic step(input bit fs, input logic [31:0] fa, input bit bv,
                        input logic [31:0] ba, input logic [31:0] bd,
                        input bit be, input bit la);
        fill_start  = fs;
        fill_addr   = fa;
        beat_valid  = bv;
        beat_addr   = ba;
        beat_data   = bd;
        beat_err    = be;
        line_accept = la;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, '0, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input bit fs, input logic [31:0] fa, input bit bv,
                                input logic [31:0] ba, input logic [31:0] bd, input bit be,
                                input bit la, input bit e_busy, input bit e_cv,
                                input logic [31:0] e_cd, input bit e_lv, input bit e_fe,
                                input bit e_line, input logic [31:0] e_la,
                                input logic [127:0] e_ld);
        vec_t v;
        v.fs = fs; v.fa = fa; v.bv = bv; v.ba = ba; v.bd = bd; v.be = be; v.la = la;
        v.e_busy = e_busy; v.e_cv = e_cv; v.e_cd = e_cd; v.e_lv = e_lv;
        v.e_fe = e_fe; v.e_line = e_line; v.e_la = e_la; v.e_ld = e_ld;
        return v;
    endfunction

    initial begin
        vec_t  vt[$];
        logic [127:0] line_a;

        rstn = 1'b0;
        fill_start = 1'b0; fill_addr = '0; beat_valid = 1'b0; beat_addr = '0;
        beat_data = '0; beat_err = 1'b0; line_accept = 1'b0;
        line_a = {A3, A2, A1, A0};

        // Reset state.
        repeat (2) @(negedge clk);
        expect_outs("reset", 0, 0, '0, 0, 0, 1'b1, '0, '0);
        chk("reset crit_data", 128'(crit_data), 128'(0));
        rstn = 1'b1;
        @(negedge clk);

        // Vector table: back-to-back wrap fill, then error abort on 2nd beat.
        vt.push_back(mk(1, 32'h1008, 0, '0, '0, 0, 0,   1, 0, '0, 0, 0, 0, '0, '0));
        vt.push_back(mk(0, '0, 1, 32'h1008, A2, 0, 0,   1, 1, A2, 0, 0, 0, '0, '0));
        vt.push_back(mk(0, '0, 1, 32'h100C, A3, 0, 0,   1, 0, '0, 0, 0, 0, '0, '0));
        vt.push_back(mk(0, '0, 1, 32'h1000, A0, 0, 0,   1, 0, '0, 0, 0, 0, '0, '0));
        vt.push_back(mk(0, '0, 1, 32'h1004, A1, 0, 0,   1, 0, '0, 1, 0, 1, 32'h1000, line_a));
        vt.push_back(mk(0, '0, 0, '0, '0, 0, 1,         0, 0, '0, 0, 0, 0, '0, '0));
        vt.push_back(mk(1, 32'h3004, 0, '0, '0, 0, 0,   1, 0, '0, 0, 0, 0, '0, '0));
        vt.push_back(mk(0, '0, 1, 32'h3004, B1, 0, 0,   1, 1, B1, 0, 0, 0, '0, '0));
        vt.push_back(mk(0, '0, 1, 32'h3008, B2, 1, 0,   0, 0, '0, 0, 1, 0, '0, '0));
        vt.push_back(mk(0, '0, 1, 32'h300C, B3, 0, 0,   0, 0, '0, 0, 0, 0, '0, '0));
        vt.push_back(mk(0, '0, 0, '0, '0, 0, 0,         0, 0, '0, 0, 0, 0, '0, '0));
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].fs, vt[i].fa, vt[i].bv, vt[i].ba, vt[i].bd, vt[i].be, vt[i].la);
            expect_outs($sformatf("vec%0d", i), vt[i].e_busy, vt[i].e_cv, vt[i].e_cd,
                        vt[i].e_lv, vt[i].e_fe, vt[i].e_line, vt[i].e_la, vt[i].e_ld);
        end

        // Gapped beats and delayed accept.
        step(1, 32'h1008, 0, '0, '0, 0, 0);  exp_s("gap start", 1, 0, '0, 0, 0);
        beat(32'h1008, A2);                   exp_s("gap b0", 1, 1, A2, 0, 0);
        idle(); exp_s("gap i0", 1, 0, '0, 0, 0);  idle(); exp_s("gap i1", 1, 0, '0, 0, 0);
        beat(32'h100C, A3);                   exp_s("gap b1", 1, 0, '0, 0, 0);
        idle(); idle();                       exp_s("gap i2", 1, 0, '0, 0, 0);
        beat(32'h1000, A0);                   exp_s("gap b2", 1, 0, '0, 0, 0);
        idle(); idle();                       exp_s("gap i3", 1, 0, '0, 0, 0);
        beat(32'h1004, A1);
        expect_outs("gap b3", 1, 0, '0, 1, 0, 1, 32'h1000, line_a);
        for (int i = 0; i < 3; i++) begin
            idle();
            expect_outs($sformatf("gap hold%0d", i), 1, 0, '0, 1, 0, 1, 32'h1000, line_a);
        end
        step(0, '0, 0, '0, '0, 0, 1);        exp_s("gap accept", 0, 0, '0, 0, 0);

        // Stray beat mid-fill, then back-to-back accept + new fill.
        step(1, 32'h1000, 0, '0, '0, 0, 0);  exp_s("stray start", 1, 0, '0, 0, 0);
        beat(32'h1000, B0);                   exp_s("stray b0", 1, 1, B0, 0, 0);
        beat(32'h1004, B1);                   exp_s("stray b1", 1, 0, '0, 0, 0);
        beat(32'h2004, 32'hFF);               exp_s("stray x", 1, 0, '0, 0, 0);
        beat(32'h1008, B2);                   exp_s("stray b2", 1, 0, '0, 0, 0);
        beat(32'h100C, B3);
        expect_outs("stray line", 1, 0, '0, 1, 0, 1, 32'h1000, {B3, B2, B1, B0});
        step(1, 32'h4000, 0, '0, '0, 0, 1);  exp_s("b2b accept", 1, 0, '0, 0, 0);
        beat(32'h400C, C3);                   exp_s("b2b b0", 1, 0, '0, 0, 0);
        beat(32'h4000, C0);                   exp_s("b2b b1", 1, 1, C0, 0, 0);
        beat(32'h4004, C1);                   exp_s("b2b b2", 1, 0, '0, 0, 0);
        beat(32'h4008, C2);
        expect_outs("b2b line", 1, 0, '0, 1, 0, 1, 32'h4000, {C3, C2, C1, C0});
        step(0, '0, 0, '0, '0, 0, 1);        exp_s("b2b done", 0, 0, '0, 0, 0);

        // Asynchronous reset in mid-fill.
        step(1, 32'h1000, 0, '0, '0, 0, 0);
        beat(32'h1000, B0);                   exp_s("rst b0", 1, 1, B0, 0, 0);
        beat(32'h1004, B1);
        rstn = 1'b0;
        #1;
        expect_outs("rst mid", 0, 0, '0, 0, 0, 1'b1, '0, '0);
        chk("rst mid crit_data", 128'(crit_data), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        step(1, 32'h1000, 0, '0, '0, 0, 0);  exp_s("rst restart", 1, 0, '0, 0, 0);
        beat(32'h1008, C2);                   exp_s("rst n0", 1, 0, '0, 0, 0);
        beat(32'h100C, C3);                   exp_s("rst n1", 1, 0, '0, 0, 0);
        beat(32'h1000, C0);                   exp_s("rst n2", 1, 1, C0, 0, 0);
        beat(32'h1004, C1);
        expect_outs("rst line", 1, 0, '0, 1, 0, 1, 32'h1000, {C3, C2, C1, C0});
        step(0, '0, 0, '0, '0, 0, 1);        exp_s("rst done", 0, 0, '0, 0, 0);

        // Randomized refills against a set-of-words model.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] addr, base, w[4];
            int          p[4], crit, tmp, j;
            bit          got[4], aborted, done, hit, ecv, elv;
            beat_t       bq[$];
            beat_t       b;

            addr = $urandom() & 32'hFFFF_FFFC;
            base = addr & ~32'hF;
            crit = int'(addr[3:2]);
            for (int k = 0; k < 4; k++) begin p[k] = k; got[k] = 0; w[k] = '0; end
            for (int k = 3; k > 0; k--) begin
                j = $urandom_range(0, k); tmp = p[k]; p[k] = p[j]; p[j] = tmp;
            end
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    b.a = base + 32'h10 * $urandom_range(1, 1000) + 32'(4 * $urandom_range(0, 3));
                    b.d = $urandom(); b.e = 0; bq.push_back(b);
                end
                if (k == 3 && $urandom_range(0, 2) == 0) begin
                    b.a = base + 32'(4 * p[0]); b.d = $urandom(); b.e = 0; bq.push_back(b);
                end
                b.a = base + 32'(4 * p[k]); b.d = $urandom(); b.e = 0; bq.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) bq[$urandom_range(0, bq.size() - 1)].e = 1;

            step(1, addr, 0, '0, '0, 0, 0);
            exp_s($sformatf("rnd%0d start", t), 1, 0, '0, 0, 0);
            aborted = 0; done = 0;
            foreach (bq[k]) begin
                repeat ($urandom_range(0, 2)) begin
                    step(1'($urandom_range(0, 1)), $urandom(), 0, $urandom(), $urandom(), 0, 0);
                    exp_s($sformatf("rnd%0d gap", t), 1, 0, '0, 0, 0);
                end
                step(0, '0, 1, bq[k].a, bq[k].d, bq[k].e, 0);
                if (bq[k].e) begin
                    exp_s($sformatf("rnd%0d err", t), 0, 0, '0, 0, 1);
                    aborted = 1;
                    break;
                end
                hit = ((bq[k].a & ~32'hF) == base);
                ecv = 0;
                if (hit) begin
                    j = int'(bq[k].a[3:2]);
                    ecv = (j == crit) && !got[j];
                    w[j] = bq[k].d;
                    got[j] = 1;
                end
                elv = got[0] && got[1] && got[2] && got[3];
                expect_outs($sformatf("rnd%0d beat%0d", t, k), 1, ecv, bq[k].d, elv, 0,
                            elv, base, {w[3], w[2], w[1], w[0]});
                done = elv;
            end
            if (aborted) begin
                idle();
                exp_s($sformatf("rnd%0d post-err", t), 0, 0, '0, 0, 0);
            end else begin
                chk($sformatf("rnd%0d complete", t), 128'(done), 128'(1));
                repeat ($urandom_range(0, 3)) begin
                    step(1'($urandom_range(0, 1)), $urandom(), 1, $urandom(), $urandom(), 0, 0);
                    expect_outs($sformatf("rnd%0d hold", t), 1, 0, '0, 1, 0, 1, base,
                                {w[3], w[2], w[1], w[0]});
                end
                step(0, '0, 0, '0, '0, 0, 1);
                exp_s($sformatf("rnd%0d accept", t), 0, 0, '0, 0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
